// File: rtl/keypad_scanner_if.sv
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad-side signal bundle for keypad_scanner. The master
//                modport is the scanner (drives columns, reports keys); the
//                slave modport is the keypad matrix / downstream consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic [4:0] row_n;      // keypad rows, active-low, asynchronous
    logic [4:0] col_n;      // column drive, active-low, one-cold
    logic       newkey;     // one-cycle pulse per accepted press
    logic [4:0] keycode;    // code of the last accepted key
    logic       keydown;    // accepted key still held

    modport master (
        input  row_n,
        output col_n,
        output newkey,
        output keycode,
        output keydown
    );

    modport slave (
        output row_n,
        input  col_n,
        input  newkey,
        input  keycode,
        input  keydown
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module      : keypad_scanner
//  Description : 5x5 matrix keypad scanner and debouncer. Rotates a single
//                low column, debounces one key at a time and emits a
//                one-cycle newkey pulse with a 5-bit keycode per press.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    keypad_scanner_if.master kp
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [TW-1:0] c_timer_last = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] c_cnt_done   = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] c_cnt_one    = CW'(1);
    localparam logic [4:0]    c_rows_idle  = 5'b11111;
    localparam logic [2:0]    c_col_last   = 3'd4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Synchronizer and dwell timer
    logic [4:0]    r_row_meta;
    logic [4:0]    r_row_sync;
    logic [TW-1:0] r_timer;

    // FSM state and datapath registers
    state_t        r_state;
    logic [2:0]    r_col;
    logic [4:0]    r_pat;
    logic [CW-1:0] r_cnt;
    logic          r_newkey;
    logic [4:0]    r_keycode;
    logic          r_keydown;

    // Next-state values
    state_t        w_state_nxt;
    logic [2:0]    w_col_nxt;
    logic [4:0]    w_pat_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_newkey_nxt;
    logic [4:0]    w_keycode_nxt;
    logic          w_keydown_nxt;

    // Helpers
    logic          w_sample;
    logic [4:0]    w_row_low;
    logic          w_any_low;
    logic          w_one_low;
    logic [2:0]    w_col_adv;
    logic [CW-1:0] w_cnt_inc;
    logic [2:0]    w_row_idx;
    logic [4:0]    w_code;
    logic          w_code_ok;

    // Two-flop synchronizer on the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= c_rows_idle;
            r_row_sync <= c_rows_idle;
        end else begin
            r_row_meta <= kp.row_n;
            r_row_sync <= r_row_meta;
        end
    end

    // Free-running dwell timer; the last dwell cycle is the sample point
    always_ff @(posedge clk) begin
        if (rst || (r_timer == c_timer_last)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    assign w_sample  = (r_timer == c_timer_last);
    assign w_row_low = ~r_row_sync;
    assign w_any_low = (w_row_low != 5'd0);
    assign w_one_low = w_any_low && ((w_row_low & (w_row_low - 5'd1)) == 5'd0);
    assign w_col_adv = (r_col == c_col_last) ? 3'd0 : (r_col + 3'd1);
    assign w_cnt_inc = r_cnt + c_cnt_one;

    // Row index of the single low bit in the latched pattern
    always_comb begin
        w_row_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (!r_pat[i]) begin
                w_row_idx = 3'(i);
            end
        end
    end

    // Key map: (row, column) of the latched press to keycode and validity
    always_comb begin
        w_code    = 5'b00000;
        w_code_ok = 1'b0;
        if ((w_row_idx < 3'd4) && (r_col < 3'd4)) begin
            w_code    = {1'b1, w_row_idx[1:0], r_col[1:0]};
            w_code_ok = 1'b1;
        end else if (w_row_idx == 3'd4) begin
            w_code_ok = 1'b1;
            case (r_col)
                3'd0:    w_code = 5'b01001;     // ADD
                3'd1:    w_code = 5'b00001;     // SUB
                3'd2:    w_code = 5'b01010;     // MULT
                3'd3:    w_code = 5'b00100;     // EQUALS
                default: w_code_ok = 1'b0;      // r4 c4 unused
            endcase
        end else begin
            w_code_ok = 1'b1;
            case (w_row_idx)
                3'd0:    w_code = 5'b01011;     // BACKSPACE
                3'd1:    w_code = 5'b00011;     // CLEAR-ALL
                default: w_code_ok = 1'b0;      // r2-r3 c4 unused
            endcase
        end
    end

    // Next-state and output logic; outputs are loaded on the edge that
    // enters PRESSED so newkey/keycode/keydown are visible in that cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_pat_nxt     = r_pat;
        w_cnt_nxt     = r_cnt;
        w_newkey_nxt  = 1'b0;
        w_keycode_nxt = r_keycode;
        w_keydown_nxt = r_keydown;

        case (r_state)
            ST_SCAN: begin
                if (w_sample) begin
                    if (w_any_low) begin
                        w_pat_nxt   = r_row_sync;
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_col_nxt   = w_col_adv;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (w_sample) begin
                    if ((r_row_sync == r_pat) && w_one_low) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_cnt_done) begin
                            w_state_nxt = ST_PRESSED;
                            if (w_code_ok) begin
                                w_newkey_nxt  = 1'b1;
                                w_keycode_nxt = w_code;
                                w_keydown_nxt = 1'b1;
                            end
                        end
                    end else begin
                        // Bounce, release or multiple keys in this column
                        w_state_nxt = ST_SCAN;
                        w_col_nxt   = w_col_adv;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            ST_PRESSED: begin
                w_state_nxt = ST_RELEASE;
                w_cnt_nxt   = '0;
            end

            ST_RELEASE: begin
                if (w_sample) begin
                    if (w_any_low) begin
                        w_cnt_nxt = '0;
                    end else if (w_cnt_inc == c_cnt_done) begin
                        w_state_nxt   = ST_SCAN;
                        w_col_nxt     = w_col_adv;
                        w_cnt_nxt     = '0;
                        w_keydown_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    // FSM state and datapath register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SCAN;
            r_col     <= 3'd0;
            r_pat     <= c_rows_idle;
            r_cnt     <= '0;
            r_newkey  <= 1'b0;
            r_keycode <= 5'b00000;
            r_keydown <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_pat     <= w_pat_nxt;
            r_cnt     <= w_cnt_nxt;
            r_newkey  <= w_newkey_nxt;
            r_keycode <= w_keycode_nxt;
            r_keydown <= w_keydown_nxt;
        end
    end

    assign kp.col_n   = ~(5'b00001 << r_col);
    assign kp.newkey  = r_newkey;
    assign kp.keycode = r_keycode;
    assign kp.keydown = r_keydown;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with a keypad matrix
//                model, directed scenarios and randomized single presses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] key_mat;        // bit r*5+c set = key (r,c) held
    logic [4:0]  mat_rows;
    logic [4:0]  exp_col;
    logic [4:0]  exp_kc;
    logic [4:0]  nk_last;
    logic [5:0]  ref_k;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          nk_count;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a held key sits on a driven column
    always_comb begin
        mat_rows = 5'b11111;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (key_mat[r*5+c] && (kp.col_n[c] == 1'b0)) begin
                    mat_rows[r] = 1'b0;
                end
            end
        end
        kp.row_n = mat_rows;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference key map: returns {valid, keycode}
    function automatic logic [5:0] ref_key(input int r, input int c);
        if (r < 4 && c < 4) return {1'b1, 1'b1, 4'(r * 4 + c)};
        if (r == 4 && c == 0) return {1'b1, 5'b01001};
        if (r == 4 && c == 1) return {1'b1, 5'b00001};
        if (r == 4 && c == 2) return {1'b1, 5'b01010};
        if (r == 4 && c == 3) return {1'b1, 5'b00100};
        if (r == 0 && c == 4) return {1'b1, 5'b01011};
        if (r == 1 && c == 4) return {1'b1, 5'b00011};
        return 6'b000000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (kp.newkey === 1'b1) begin
            nk_count++;
            nk_last = kp.keycode;
        end
        check("col_onecold", $countones(~kp.col_n), 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int r, input int c);
        key_mat[r*5+c] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int k;
        int rr;
        int cc;
        n_checks = 0;
        n_fail   = 0;
        nk_count = 0;
        nk_last  = 5'b0;
        key_mat  = '0;
        rst      = 1'b1;
        cyc      = 0;
        exp_kc   = 5'b00000;

        // 1. Reset values and idle column rotation
        do_reset();
        check("rst_col", kp.col_n, 5'b11110);
        check("rst_newkey", kp.newkey, 0);
        check("rst_keycode", kp.keycode, 0);
        check("rst_keydown", kp.keydown, 0);
        for (int m = 1; m <= 20; m++) begin
            tick();
            exp_col = ~(5'b00001 << ((m / SCAN_DIV) % 5));
            check("idle_col", kp.col_n, exp_col);
            check("idle_newkey", kp.newkey, 0);
            check("idle_keycode", kp.keycode, 0);
            check("idle_keydown", kp.keydown, 0);
        end

        // 2. Clean press of r2 c3: col3 sampled at cycle 35, pulse at 35+9
        press(2, 3);
        nk_count = 0;
        while (cyc < 60) begin
            tick();
            check("t2_newkey", kp.newkey, (cyc == 44));
            if (cyc == 44) begin
                check("t2_keycode", kp.keycode, 5'b11011);
                check("t2_keydown", kp.keydown, 1);
            end
        end
        check("t2_count", nk_count, 1);
        key_mat = '0;
        // Released at 60: all-high samples at 63, 67, 71
        while (cyc < 72) begin
            tick();
            check("t2_keydown_rel", kp.keydown, (cyc < 72));
        end
        check("t2_resume_c4", kp.col_n, 5'b01111);
        exp_kc = 5'b11011;
        check("t2_kc_hold", kp.keycode, exp_kc);

        // 3. Bounce on r4 c1, phased so every sample of column 1 sees it open
        while ((cyc % SCAN_DIV) != 2) tick();
        nk_count = 0;
        for (int i = 0; i < 20; i++) begin
            key_mat[4*5+1] = (((i / 2) % 2) == 0);
            tick();
        end
        check("t3_no_bounce_pulse", nk_count, 0);
        press(4, 1);
        ticks(80);
        check("t3_count", nk_count, 1);
        check("t3_code", nk_last, 5'b00001);
        check("t3_keydown", kp.keydown, 1);
        key_mat = '0;
        ticks(40);
        check("t3_keyup", kp.keydown, 0);
        exp_kc = 5'b00001;

        // 4. Long hold of BACKSPACE, then a second press
        nk_count = 0;
        press(0, 4);
        ticks(200);
        check("t4_count", nk_count, 1);
        check("t4_code", nk_last, 5'b01011);
        check("t4_keydown", kp.keydown, 1);
        key_mat = '0;
        ticks(40);
        check("t4_keyup", kp.keydown, 0);
        press(0, 4);
        ticks(100);
        check("t4_count2", nk_count, 2);
        check("t4_code2", kp.keycode, 5'b01011);
        key_mat = '0;
        ticks(40);
        exp_kc = 5'b01011;

        // 5a. Two keys in one column are rejected
        nk_count = 0;
        press(0, 0);
        press(3, 0);
        ticks(100);
        check("t5_same_col", nk_count, 0);
        check("t5_same_col_kd", kp.keydown, 0);
        check("t5_same_col_kc", kp.keycode, exp_kc);
        key_mat = '0;
        ticks(40);

        // 5b. r3 c2 ignored while r1 c1 held, accepted after its release
        press(1, 1);
        ticks(60);
        check("t5_first_count", nk_count, 1);
        check("t5_first_code", nk_last, 5'b10101);
        press(3, 2);
        ticks(100);
        check("t5_ignored", nk_count, 1);
        check("t5_kc_hold", kp.keycode, 5'b10101);
        key_mat[1*5+1] = 1'b0;
        ticks(100);
        check("t5_second_count", nk_count, 2);
        check("t5_second_code", nk_last, 5'b11110);
        key_mat = '0;
        ticks(40);
        check("t5_keyup", kp.keydown, 0);
        exp_kc = 5'b11110;

        // 6a. Unused position r3 c4
        nk_count = 0;
        press(3, 4);
        ticks(100);
        check("t6_unused_count", nk_count, 0);
        check("t6_unused_kd", kp.keydown, 0);
        check("t6_unused_kc", kp.keycode, exp_kc);
        key_mat = '0;
        ticks(40);

        // 6b. Reset while r4 c3 is being debounced
        k = 0;
        while (kp.col_n !== 5'b11110 && k < 40) begin
            tick();
            k++;
        end
        check("t6_wait_c0", (k < 40), 1);
        press(4, 3);
        k = 0;
        while (kp.col_n !== 5'b10111 && k < 40) begin
            tick();
            k++;
        end
        check("t6_wait_c3", (k < 40), 1);
        ticks(SCAN_DIV + 2);           // past the detecting sample, mid-debounce
        rst     = 1'b1;
        key_mat = '0;
        tick();
        check("t6_rst_col", kp.col_n, 5'b11110);
        check("t6_rst_newkey", kp.newkey, 0);
        check("t6_rst_keycode", kp.keycode, 0);
        check("t6_rst_keydown", kp.keydown, 0);
        rst = 1'b0;
        ticks(60);
        check("t6_rst_no_key", nk_count, 0);
        exp_kc = 5'b00000;

        // Randomized single presses against the reference key map
        for (int t = 0; t < 16; t++) begin
            rr    = $urandom_range(0, 4);
            cc    = $urandom_range(0, 4);
            ref_k = ref_key(rr, cc);
            nk_count = 0;
            key_mat  = '0;
            press(rr, cc);
            ticks($urandom_range(60, 150));
            check("rnd_count", nk_count, {31'd0, ref_k[5]});
            if (ref_k[5]) begin
                exp_kc = ref_k[4:0];
                check("rnd_code", nk_last, exp_kc);
            end
            check("rnd_keycode", kp.keycode, exp_kc);
            check("rnd_keydown", kp.keydown, {31'd0, ref_k[5]});
            key_mat = '0;
            ticks($urandom_range(40, 80));
            check("rnd_keyup", kp.keydown, 0);
            check("rnd_no_extra", nk_count, {31'd0, ref_k[5]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
